cache_bus_arbiter: RTL and testbench
====================================

# cache_bus_arbiter

Two-master, one-slave arbiter for the core's cache port. It shares the single cache/memory bus between the instruction-fetch master (pc stage, read-only) and the data master (load/store unit, read/write). Read responses return in order, and the arbiter routes each one back to the master that issued it. It sits between the pipeline masters and the cache, using the same pipelined read/write/waitrequest/readdata_valid protocol on every side.

## Interface
Parameters:
- ADDR_W, 25, cache address width
- DATA_W, 32, data width
- BE_W, 4, byte-enable width
- MAX_OUT, 4, maximum outstanding reads (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- m0_addr / m0_read  in  ADDR_W / 1  fetch master command (read-only)
- m0_readdata  out  DATA_W  fetch read data
- m0_readdata_valid / m0_waitrequest  out  1 / 1  fetch response and stall
- m1_addr / m1_byte_en / m1_writedata  in  ADDR_W / BE_W / DATA_W  data master command
- m1_read / m1_write  in  1 / 1  data master strobes (never both high)
- m1_readdata / m1_readdata_valid / m1_waitrequest  out  DATA_W / 1 / 1  data master response and stall
- s_addr / s_byte_en / s_writedata / s_read / s_write  out  slave command
- s_readdata / s_readdata_valid / s_waitrequest  in  slave response
- err_o  out  1  sticky error: response received with no read outstanding

## Operation
- Request: m0_req = m0_read; m1_req = m1_read | m1_write.
- Lock FSM, two states:
  - IDLE: grant is combinational.
    - One requester: it wins.
    - Both request: round-robin. The winner is the master not recorded in last_gnt.
    - Winner's command drives s_*.
    - s_waitrequest=1 with a request present → LOCKED, holding the winner in gnt_q.
  - LOCKED: s_* driven from gnt_q's master regardless of other requests.
    - Returns to IDLE on the cycle the command is accepted.
- Accept = s_read|s_write high and s_waitrequest low.
  - On accept, last_gnt ← granted master.
  - For reads, the owner id is pushed into the owner FIFO.
- Stall outputs:
  - Granted master: mX_waitrequest = s_waitrequest | full_block.
  - Losing master: mX_waitrequest = 1.
  - Idle master: mX_waitrequest = 0.
  - full_block: MAX_OUT reads outstanding and the granted command is a read. s_read is forced to 0 while blocked; writes may still pass.
- Response: s_readdata_valid pops the FIFO head. The head owner's mX_readdata_valid=1 and its mX_readdata = s_readdata. The other master's valid=0. Both readdata buses are wired to s_readdata.
- s_readdata_valid with the FIFO empty: dropped (no pop), err_o set until reset.
- Writes produce no response and are not tracked.
- No request: s_read=s_write=0, s_addr/s_byte_en/s_writedata=0.

## Timing
- Command path is combinational, master → slave, with zero added latency. Response path is also combinational, with zero added latency.
- Push and pop in the same cycle leave the count unchanged. This is legal even when full; the pop takes effect before the full check, so a read may be accepted.
- Reset values:
  - FSM=IDLE, gnt_q=0, last_gnt=1 (fetch wins the first tie), FIFO empty, count=0, err_o=0.
  - During rst: s_read=s_write=0 and both mX_waitrequest=1.
- Reset mid-operation clears the FIFO; responses to reads issued before reset raise err_o. The slave shares rst, so this occurs only on slave misbehaviour.
- Master protocol: hold the command stable while mX_waitrequest=1. The arbiter's lock guarantees the slave sees a stable command.

## Structure
- Shared package/defines: master id encoding (MID_FETCH=0, MID_DATA=1), FSM state codes (ST_IDLE, ST_LOCKED), reuse of existing CacheAddrBus/CacheDataBus/CacheByteBus widths.
- Sub-module: owner_fifo, a MAX_OUT-deep × 1-bit synchronous FIFO. It has push/pop/full/empty/count, pointers that wrap modulo MAX_OUT, and a count width of clog2(MAX_OUT)+1.

## Test plan
- Lone fetch: m0_read, addr 0x10, slave waitrequest 0, data 0xDEADBEEF returned 2 cycles later → m0 sees valid with 0xDEADBEEF; m1_readdata_valid stays 0.
- Contention: both request every cycle, no waitrequest → grants alternate fetch, data, fetch, …; first tie after reset goes to fetch.
- Lock: m1 write to 0x20 with s_waitrequest=1 for 3 cycles while m0 requests → s_* hold the write for all 4 cycles; m0_waitrequest=1; fetch granted the next cycle.
- Ordering: issue fetch, data, fetch reads, then return 0x1, 0x2, 0x3 → valids go to m0, m1, m0 respectively.
- Full: MAX_OUT=4, four fetch reads with no response → fifth read sees s_read=0 and m0_waitrequest=1. A response on the same cycle as the fifth request is accepted with count still 4.
- Error: s_readdata_valid pulse with nothing outstanding → no master valid; err_o=1 until rst.

Source files
------------

// File: rtl/cache_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_bus_arbiter_pkg : shared ids, state codes and bus widths       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cache_bus_arbiter_pkg;
  localparam int CACHE_ADDR_W = 25;  // CacheAddrBus
  localparam int CACHE_DATA_W = 32;  // CacheDataBus
  localparam int CACHE_BYTE_W = 4;   // CacheByteBus

  localparam logic MID_FETCH = 1'b0;
  localparam logic MID_DATA  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/cache_bus_arbiter_owner_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_bus_arbiter_owner_fifo : DEPTH x 1-bit read-owner FIFO         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cache_bus_arbiter_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       push_id,
  input  logic                       pop,
  output logic                       head_id,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_id   = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_bus_arbiter : fetch/data master arbiter for the cache port     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = CACHE_ADDR_W,
  parameter int DATA_W  = CACHE_DATA_W,
  parameter int BE_W    = CACHE_BYTE_W,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_read,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdata_valid,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [BE_W-1:0]   m1_byte_en,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_read,
  input  logic              m1_write,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdata_valid,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_addr,
  output logic [BE_W-1:0]   s_byte_en,
  output logic [DATA_W-1:0] s_writedata,
  output logic              s_read,
  output logic              s_write,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdata_valid,
  input  logic              s_waitrequest,
  output logic              err_o
);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  arb_state_t       r_state;
  logic             r_gnt_q;
  logic             r_last_gnt;
  logic             r_err;
  logic             w_m0_req;
  logic             w_m1_req;
  logic             w_any;
  logic             w_gnt;
  logic             w_cmd_read;
  logic             w_cmd_write;
  logic             w_full_block;
  logic             w_pop;
  logic             w_accept;
  logic             w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_count;

  assign w_m0_req = m0_read;
  assign w_m1_req = m1_read | m1_write;
  assign w_pop    = ~rst & s_readdata_valid & ~w_fifo_empty;

  always_comb begin
    w_any = 1'b0;
    w_gnt = MID_FETCH;
    if (!rst) begin
      if (r_state == ST_LOCKED) begin
        w_any = 1'b1;
        w_gnt = r_gnt_q;
      end else begin
        w_any = w_m0_req | w_m1_req;
        if (w_m0_req && w_m1_req) w_gnt = ~r_last_gnt;
        else if (w_m1_req)        w_gnt = MID_DATA;
      end
    end
  end

  assign w_cmd_read  = w_any & ((w_gnt == MID_DATA) ? m1_read : m0_read);
  assign w_cmd_write = w_any & (w_gnt == MID_DATA) & m1_write;
  // A same-cycle response frees a slot before the capacity check.
  assign w_full_block = w_fifo_full & ~w_pop & w_cmd_read;

  assign s_read      = w_cmd_read & ~w_full_block;
  assign s_write     = w_cmd_write;
  assign s_addr      = !w_any ? '0 : (w_gnt == MID_DATA) ? m1_addr : m0_addr;
  assign s_byte_en   = (w_any && w_gnt == MID_DATA) ? m1_byte_en : {BE_W{w_any}};
  assign s_writedata = (w_any && w_gnt == MID_DATA) ? m1_writedata : '0;
  assign w_accept    = (s_read | s_write) & ~s_waitrequest;

  always_comb begin
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (!rst) begin
      if (w_any && w_gnt == MID_FETCH) m0_waitrequest = s_waitrequest | w_full_block;
      else                             m0_waitrequest = w_m0_req;
      if (w_any && w_gnt == MID_DATA)  m1_waitrequest = s_waitrequest | w_full_block;
      else                             m1_waitrequest = w_m1_req;
    end
  end

  assign m0_readdata       = s_readdata;
  assign m1_readdata       = s_readdata;
  assign m0_readdata_valid = w_pop & (w_head == MID_FETCH);
  assign m1_readdata_valid = w_pop & (w_head == MID_DATA);
  assign err_o             = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt_q    <= MID_FETCH;
      r_last_gnt <= MID_DATA;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) r_last_gnt <= w_gnt;
      if (s_readdata_valid && w_count == '0) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_any && s_waitrequest) begin
            r_state <= ST_LOCKED;
            r_gnt_q <= w_gnt;
          end
        end
        ST_LOCKED: begin
          if (w_accept) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  cache_bus_arbiter_owner_fifo #(
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_accept & s_read),
    .push_id (w_gnt),
    .pop     (w_pop),
    .head_id (w_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_count)
  );
endmodule
`default_nettype wire

// File: tb/tb_cache_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_bus_arbiter : directed self-checking bench                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cache_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] m0_addr, m1_addr, s_addr;
  logic        m0_read, m1_read, m1_write;
  logic [3:0]  m1_byte_en, s_byte_en;
  logic [31:0] m1_writedata, s_writedata, s_readdata;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdata_valid, m1_readdata_valid;
  logic        m0_waitrequest, m1_waitrequest;
  logic        s_read, s_write, s_readdata_valid, s_waitrequest, err_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(
    .ADDR_W (25), .DATA_W (32), .BE_W (4), .MAX_OUT (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .m0_addr           (m0_addr),
    .m0_read           (m0_read),
    .m0_readdata       (m0_readdata),
    .m0_readdata_valid (m0_readdata_valid),
    .m0_waitrequest    (m0_waitrequest),
    .m1_addr           (m1_addr),
    .m1_byte_en        (m1_byte_en),
    .m1_writedata      (m1_writedata),
    .m1_read           (m1_read),
    .m1_write          (m1_write),
    .m1_readdata       (m1_readdata),
    .m1_readdata_valid (m1_readdata_valid),
    .m1_waitrequest    (m1_waitrequest),
    .s_addr            (s_addr),
    .s_byte_en         (s_byte_en),
    .s_writedata       (s_writedata),
    .s_read            (s_read),
    .s_write           (s_write),
    .s_readdata        (s_readdata),
    .s_readdata_valid  (s_readdata_valid),
    .s_waitrequest     (s_waitrequest),
    .err_o             (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_read = 0; m0_addr = '0;
    m1_read = 0; m1_write = 0; m1_addr = '0; m1_byte_en = '0; m1_writedata = '0;
    s_readdata = '0; s_readdata_valid = 0; s_waitrequest = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m0_read = 1; m1_write = 1;
    tick(); #1;
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    tick();
    idle_inputs();
    rst = 0;
    #1;
    chk("rst_err", err_o, 0);
    chk("idle_s_addr", s_addr, 0);
    chk("idle_m0_wait", m0_waitrequest, 0);

    // Lone fetch, response two cycles later
    m0_read = 1; m0_addr = 25'h10;
    #1;
    chk("lone_s_read", s_read, 1);
    chk("lone_s_addr", s_addr, 25'h10);
    chk("lone_m0_wait", m0_waitrequest, 0);
    tick();
    m0_read = 0;
    tick();
    s_readdata_valid = 1; s_readdata = 32'hDEADBEEF;
    #1;
    chk("lone_m0_valid", m0_readdata_valid, 1);
    chk("lone_m0_data", m0_readdata, 32'hDEADBEEF);
    chk("lone_m1_valid", m1_readdata_valid, 0);
    tick();

    // Contention from reset: fetch, data, fetch
    do_reset();
    m0_read = 1; m0_addr = 25'h100;
    m1_write = 1; m1_addr = 25'h200; m1_writedata = 32'h55; m1_byte_en = 4'hF;
    #1;
    chk("rr0_s_read", s_read, 1);
    chk("rr0_s_addr", s_addr, 25'h100);
    chk("rr0_m1_wait", m1_waitrequest, 1);
    tick();
    chk("rr1_s_write", s_write, 1);
    chk("rr1_s_addr", s_addr, 25'h200);
    chk("rr1_s_wdata", s_writedata, 32'h55);
    chk("rr1_m0_wait", m0_waitrequest, 1);
    tick();
    chk("rr2_s_addr", s_addr, 25'h100);
    chk("rr2_m1_wait", m1_waitrequest, 1);
    tick();

    // Lock: data write stalled 3 cycles while fetch waits
    m0_addr = 25'h30;
    m1_addr = 25'h20; m1_writedata = 32'hCAFE;
    s_waitrequest = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_s_write", s_write, 1);
      chk("lock_s_addr", s_addr, 25'h20);
      chk("lock_m0_wait", m0_waitrequest, 1);
      chk("lock_m1_wait", m1_waitrequest, 1);
      tick();
    end
    s_waitrequest = 0;
    #1;
    chk("lock4_s_write", s_write, 1);
    chk("lock4_s_addr", s_addr, 25'h20);
    chk("lock4_m1_wait", m1_waitrequest, 0);
    chk("lock4_m0_wait", m0_waitrequest, 1);
    tick();
    m1_write = 0;
    #1;
    chk("post_lock_s_read", s_read, 1);
    chk("post_lock_s_addr", s_addr, 25'h30);
    tick();
    m0_read = 0;
    for (int i = 0; i < 3; i++) begin
      s_readdata_valid = 1; s_readdata = 32'(i);
      #1;
      chk("drain_m0_valid", m0_readdata_valid, 1);
      chk("drain_m1_valid", m1_readdata_valid, 0);
      tick();
    end
    s_readdata_valid = 0;

    // Ordering: fetch, data, fetch reads
    m0_read = 1; m0_addr = 25'h1; tick(); m0_read = 0;
    m1_read = 1; m1_addr = 25'h2; #1;
    chk("ord_s_read_data", s_read, 1);
    tick(); m1_read = 0;
    m0_read = 1; m0_addr = 25'h3; tick(); m0_read = 0;
    s_readdata_valid = 1;
    s_readdata = 32'h1; #1;
    chk("ord1_m0_valid", m0_readdata_valid, 1);
    chk("ord1_m1_valid", m1_readdata_valid, 0);
    tick();
    s_readdata = 32'h2; #1;
    chk("ord2_m0_valid", m0_readdata_valid, 0);
    chk("ord2_m1_valid", m1_readdata_valid, 1);
    chk("ord2_m1_data", m1_readdata, 32'h2);
    tick();
    s_readdata = 32'h3; #1;
    chk("ord3_m0_valid", m0_readdata_valid, 1);
    chk("ord3_m1_valid", m1_readdata_valid, 0);
    tick();
    s_readdata_valid = 0;

    // Full: four outstanding fetch reads block the fifth
    m0_read = 1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 25'h40 + 25'(i);
      #1;
      chk("fill_s_read", s_read, 1);
      tick();
    end
    m0_addr = 25'h44;
    #1;
    chk("full_s_read", s_read, 0);
    chk("full_m0_wait", m0_waitrequest, 1);
    tick();
    s_readdata_valid = 1; s_readdata = 32'h77;
    #1;
    chk("full_pop_m0_valid", m0_readdata_valid, 1);
    chk("full_pop_s_read", s_read, 1);
    chk("full_pop_m0_wait", m0_waitrequest, 0);
    tick();
    s_readdata_valid = 0;
    #1;
    chk("still_full_s_read", s_read, 0);
    m0_read = 0;
    m1_write = 1; m1_addr = 25'h50; m1_writedata = 32'h99;
    #1;
    chk("full_write_pass", s_write, 1);
    chk("full_write_m1_wait", m1_waitrequest, 0);
    tick();
    m1_write = 0;
    for (int i = 0; i < 4; i++) begin
      s_readdata_valid = 1;
      #1;
      chk("full_drain_m0_valid", m0_readdata_valid, 1);
      tick();
    end
    s_readdata_valid = 0;

    // Error: response with nothing outstanding
    #1;
    chk("pre_err", err_o, 0);
    s_readdata_valid = 1;
    #1;
    chk("err_m0_valid", m0_readdata_valid, 0);
    chk("err_m1_valid", m1_readdata_valid, 0);
    tick();
    s_readdata_valid = 0;
    #1;
    chk("err_set", err_o, 1);
    tick();
    chk("err_sticky", err_o, 1);
    do_reset();
    #1;
    chk("err_cleared", err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
